debug_capture_mux: RTL and testbench
====================================

// Module: debug_capture_mux
// PURPOSE
// - Successor to the combinational DIP-switch debug selector in the CPU top level. Feeds display_engine.debug.
// - Selects one of NUM_CH debug channels (core, mem, keyboard, ...) and registers it, with live, hold-on-valid,
//   triggered capture into a circular history buffer, and step-through playback.
// PARAMETERS
// - NUM_CH   4   number of debug channels (>=2)
// - DATA_W   32  channel / output width
// - DEPTH    8   history buffer entries (power of 2, >=4)
// - POST     4   valid samples captured after the trigger sample (1..DEPTH-1)
// PORTS
// - CLK_CPU     in   1                   clock; all logic on rising edge
// - resetp      in   1                   synchronous, active-high reset
// - ch_data     in   NUM_CH*DATA_W       channel n at bits [n*DATA_W +: DATA_W]
// - ch_valid    in   NUM_CH              per-channel sample-valid strobe
// - sel         in   $clog2(NUM_CH)      channel select (live/hold); latched on arm for capture
// - mode        in   2                   00 live, 01 hold, 10 capture, 11 playback
// - arm         in   1                   1-cycle pulse: clear history, enter ARMED
// - trig_mask   in   DATA_W              compare mask
// - trig_value  in   DATA_W              compare value
// - step        in   1                   playback advance (level; rising edge detected internally)
// - debug       out  DATA_W              registered debug word
// - triggered   out  1                   sticky, set at trigger, cleared by arm/reset
// - capture_done out 1                   high in DONE
// - hist_count  out  $clog2(DEPTH+1)     valid entries in buffer (saturates at DEPTH)
// BEHAVIOUR
// - Reset: debug=0, triggered=0, capture_done=0, hist_count=0, wr/rd ptrs=0, state=IDLE, step_q=0, sel_cap=0.
// - Live (00): debug <= ch_data[sel] every cycle; 1-cycle latency.
// - Hold (01): debug <= ch_data[sel] only when ch_valid[sel]; otherwise holds.
// - Capture FSM, runs in every mode once armed; sample = ch_data[sel_cap] when ch_valid[sel_cap].
//   IDLE  : arm -> ARMED.
//   ARMED : each sample written at wr_ptr, wr_ptr++ mod DEPTH, hist_count sat++ (oldest overwritten).
//           Hit = ((sample ^ trig_value) & trig_mask)==0. Hit -> write sample, record trig_ptr, triggered=1, post_cnt=0, -> POST.
//   POST  : each sample written; post_cnt++; when post_cnt reaches POST -> DONE (last write in the same cycle).
//   DONE  : no writes; capture_done=1; rd_ptr <= trig_ptr on entry.
// - arm in any state: sel_cap<=sel, wr_ptr=0, hist_count=0, triggered=0, capture_done=0, -> ARMED.
//   A sample valid in the arm cycle is NOT written or compared (arm wins).
// - mask=0: first valid sample after arm triggers.
// - Capture (10): debug <= last written sample; in DONE, debug <= buffer[trig_ptr].
// - Playback (11): debug <= buffer[rd_ptr] (1 cycle). Step rising edge: rd_ptr <= (rd_ptr+1) mod hist_count,
//   oldest-first wrap. If hist_count=0, debug=0 and step is ignored.
// - Mode and sel changes never alter FSM or buffer contents. Only arm and resetp do.
// - Reset mid-capture aborts to IDLE. Buffer RAM contents are don't-care but unreadable since hist_count=0.
// CONFIGURATION
// - DEBUG_CAPTURE_TIMESTAMP_EN defined: 32-bit free-running cycle counter, reset 0, wraps at 2^32.
//   Stored with every buffer write. Extra output port debug_ts[31:0] shows the stamp of the entry shown on
//   debug in capture/playback modes, and 0 in live/hold.
// - Not defined: no counter, no timestamp storage, no debug_ts port.
// TESTING
// - Live: NUM_CH=4, sel=2, ch2=32'hDEADBEEF -> debug=DEADBEEF one cycle later; sel=0 -> ch0 next cycle.
// - Hold: mode=01, ch_valid[1] pulse with 32'h12 then data changes to 32'h34 without valid -> debug stays 12.
// - Trigger: arm, sel=0, mask=FFFFFFFF, value=5. Feed valid 1..12 -> triggered after 5,
//   capture_done after 9, hist_count=8, debug=5 in mode 10.
// - Playback: after previous test, mode=11, 8 step edges -> buffer[trig_ptr]=5, 6, 7, 8, 9, 2, 3, 4, then 5 again.
//   Level-held step advances once.
// - Arm collision: arm with a valid matching sample in the same cycle -> not triggered, hist_count=0.
//   Next matching valid sample triggers.
// - Reset mid-POST: resetp during POST -> next cycle all outputs 0, state IDLE, samples ignored until arm.

Source files
------------

// File: rtl/debug_capture_mux.sv
// debug_capture_mux: registered debug-channel selector (live/hold) with triggered circular capture and step playback; 1-cycle output latency.
// Define DEBUG_CAPTURE_TIMESTAMP_EN to add a per-entry cycle stamp, shown on the extra debug_ts port.
module debug_capture_mux #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int POST   = 4
) (
  input  logic                         CLK_CPU,
  input  logic                         resetp,
  input  logic [NUM_CH*DATA_W-1:0]     ch_data,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [$clog2(NUM_CH)-1:0]    sel,
  input  logic [1:0]                   mode,
  input  logic                         arm,
  input  logic [DATA_W-1:0]            trig_mask,
  input  logic [DATA_W-1:0]            trig_value,
  input  logic                         step,
  output logic [DATA_W-1:0]            debug,
  output logic                         triggered,
  output logic                         capture_done,
  output logic [$clog2(DEPTH+1)-1:0]   hist_count
`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
  , output logic [31:0]                debug_ts
`endif
);

  localparam int SW = $clog2(NUM_CH);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0] buffer [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, trig_ptr;
  logic [CW-1:0]     post_cnt, rd_nx;
  logic [SW-1:0]     sel_cap;
  logic [DATA_W-1:0] last_wr, live_smp, cap_smp;
  logic              live_vld, cap_vld, hit, wr_en, trig_set, step_q, step_edge;

  assign live_smp  = ch_data[int'(sel)*DATA_W +: DATA_W];
  assign live_vld  = ch_valid[sel];
  assign cap_smp   = ch_data[int'(sel_cap)*DATA_W +: DATA_W];
  assign cap_vld   = ch_valid[sel_cap];
  assign hit       = ((cap_smp ^ trig_value) & trig_mask) == '0;
  assign step_edge = step & ~step_q;
  assign rd_nx     = CW'(rd_ptr) + CW'(1);
  assign capture_done = (state == S_DONE);

  // arm overrides everything, so a sample arriving with arm is never written or compared
  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    trig_set = 1'b0;
    if (arm) begin
      state_nx = S_ARMED;
    end else begin
      case (state)
        S_ARMED: if (cap_vld) begin
          wr_en = 1'b1;
          if (hit) begin
            trig_set = 1'b1;
            state_nx = S_POST;
          end
        end
        S_POST: if (cap_vld) begin
          wr_en = 1'b1;
          if (post_cnt == CW'(POST-1)) state_nx = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_CPU) begin
    if (wr_en && !resetp) buffer[wr_ptr] <= cap_smp;
  end

  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      trig_ptr   <= '0;
      post_cnt   <= '0;
      sel_cap    <= '0;
      last_wr    <= '0;
      step_q     <= 1'b0;
      triggered  <= 1'b0;
      hist_count <= '0;
      debug      <= '0;
    end else begin
      state  <= state_nx;
      step_q <= step;
      if (arm) begin
        sel_cap    <= sel;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        post_cnt   <= '0;
        last_wr    <= '0;
        hist_count <= '0;
        triggered  <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr  <= wr_ptr + AW'(1);
          last_wr <= cap_smp;
          if (hist_count != CW'(DEPTH)) hist_count <= hist_count + CW'(1);
        end
        if (trig_set) begin
          trig_ptr  <= wr_ptr;
          triggered <= 1'b1;
          post_cnt  <= '0;
        end else if (state == S_POST && wr_en) begin
          post_cnt <= post_cnt + CW'(1);
        end
        // entering DONE parks playback on the trigger entry
        if (state != S_DONE && state_nx == S_DONE) begin
          rd_ptr <= trig_ptr;
        end else if (mode == 2'b11 && step_edge && hist_count != '0) begin
          rd_ptr <= (rd_nx >= hist_count) ? '0 : rd_nx[AW-1:0];
        end
      end
      case (mode)
        2'b00: debug <= live_smp;
        2'b01: if (live_vld) debug <= live_smp;
        2'b10: begin
          if (state == S_DONE) debug <= buffer[trig_ptr];
          else                 debug <= wr_en ? cap_smp : last_wr;
        end
        default: debug <= (hist_count == '0) ? '0 : buffer[rd_ptr];
      endcase
    end
  end

`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt, last_ts;
  logic [31:0] ts_mem [DEPTH];

  always_ff @(posedge CLK_CPU) begin
    if (wr_en && !resetp) ts_mem[wr_ptr] <= ts_cnt;
  end

  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      ts_cnt   <= '0;
      last_ts  <= '0;
      debug_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (arm)        last_ts <= '0;
      else if (wr_en) last_ts <= ts_cnt;
      case (mode)
        2'b10: begin
          if (state == S_DONE) debug_ts <= ts_mem[trig_ptr];
          else                 debug_ts <= wr_en ? ts_cnt : last_ts;
        end
        2'b11:   debug_ts <= (hist_count == '0) ? '0 : ts_mem[rd_ptr];
        default: debug_ts <= '0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_debug_capture_mux.sv
// Bench for debug_capture_mux: directed steps from the block description, then random traffic against a queue-based history model.
module tb_debug_capture_mux;
  localparam int DEPTH = 8;
  localparam int POST  = 4;

  logic        clk;
  logic        resetp;
  logic [127:0] ch_data;
  logic [3:0]  ch_valid;
  logic [1:0]  sel;
  logic [1:0]  mode;
  logic        arm;
  logic [31:0] trig_mask;
  logic [31:0] trig_value;
  logic        step;
  logic [31:0] debug;
  logic        triggered;
  logic        capture_done;
  logic [3:0]  hist_count;
`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
  logic [31:0] debug_ts;
`endif

  debug_capture_mux #(.NUM_CH(4), .DATA_W(32), .DEPTH(DEPTH), .POST(POST)) dut (
    .CLK_CPU(clk), .resetp(resetp), .ch_data(ch_data), .ch_valid(ch_valid), .sel(sel),
    .mode(mode), .arm(arm), .trig_mask(trig_mask), .trig_value(trig_value), .step(step),
    .debug(debug), .triggered(triggered), .capture_done(capture_done), .hist_count(hist_count)
`ifdef DEBUG_CAPTURE_TIMESTAMP_EN
    , .debug_ts(debug_ts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: the history window is the last DEPTH samples written since arm, oldest first
  logic [31:0] win[$];
  int          tpos, m_postcnt, m_pb;
  bit          m_active, m_trig, m_done, m_triggered, m_step_q, m_known;
  logic [1:0]  m_selc;
  logic [31:0] m_dbg;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] chan(input int n);
    return ch_data[n*32 +: 32];
  endfunction

  task automatic set_ch(input int n, input logic [31:0] v);
    ch_data[n*32 +: 32] = v;
  endtask

  task automatic model_step();
    logic [31:0] smp;
    bit          vld, ww, edge_s;
    int          len_pre;
    if (resetp) begin
      win.delete();
      m_active = 0; m_trig = 0; m_done = 0; m_triggered = 0; m_step_q = 0;
      m_dbg = '0; m_known = 1; m_selc = '0; m_pb = 0; tpos = 0; m_postcnt = 0;
      return;
    end
    smp     = chan(int'(m_selc));
    vld     = ch_valid[m_selc];
    len_pre = win.size();
    ww      = !arm && vld && m_active && !m_done;
    case (mode)
      2'b00: begin m_dbg = chan(int'(sel)); m_known = 1; end
      2'b01: if (ch_valid[sel]) begin m_dbg = chan(int'(sel)); m_known = 1; end
      2'b10: begin
        if (m_done)           begin m_dbg = win[tpos]; m_known = 1; end
        else if (ww)          begin m_dbg = smp; m_known = 1; end
        else if (len_pre > 0) begin m_dbg = win[len_pre-1]; m_known = 1; end
        else                  m_known = 0;
      end
      default: begin
        if (len_pre == 0) begin m_dbg = '0; m_known = 1; end
        else if (m_done)  begin m_dbg = win[m_pb]; m_known = 1; end
        else              m_known = 0;
      end
    endcase
    edge_s = step && !m_step_q;
    if (arm) begin
      win.delete();
      m_active = 1; m_trig = 0; m_done = 0; m_triggered = 0; m_selc = sel; m_pb = 0;
    end else begin
      if (mode == 2'b11 && edge_s && len_pre > 0) m_pb = (m_pb + 1) % len_pre;
      if (ww) begin
        win.push_back(smp);
        if (win.size() > DEPTH) begin
          void'(win.pop_front());
          tpos--;
        end
        if (!m_trig) begin
          if (((smp ^ trig_value) & trig_mask) == 32'd0) begin
            m_trig = 1; m_triggered = 1; tpos = win.size() - 1; m_postcnt = 0;
          end
        end else begin
          m_postcnt++;
          if (m_postcnt == POST) begin m_done = 1; m_pb = tpos; end
        end
      end
    end
    m_step_q = step;
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    if (m_known) check({tag, ".debug"}, 64'(debug), 64'(m_dbg));
    check({tag, ".triggered"}, 64'(triggered), 64'(m_triggered));
    check({tag, ".capture_done"}, 64'(capture_done), 64'(m_done));
    check({tag, ".hist_count"}, 64'(hist_count), 64'(win.size()));
  endtask

  initial begin
    logic [31:0] pb_exp [8];
    pb_exp = '{32'd6, 32'd7, 32'd8, 32'd9, 32'd2, 32'd3, 32'd4, 32'd5};
    resetp = 1; ch_data = '0; ch_valid = '0; sel = '0; mode = '0; arm = 0;
    trig_mask = '0; trig_value = '0; step = 0;
    @(posedge clk); #1;
    cyc("reset");
    cyc("reset");
    check("reset_debug", 64'(debug), 64'd0);
    check("reset_hist", 64'(hist_count), 64'd0);
    resetp = 0;

    // live
    mode = 2'b00; sel = 2; set_ch(2, 32'hDEADBEEF); set_ch(0, 32'h11111111);
    cyc("live");
    check("live_sel2", 64'(debug), 64'hDEADBEEF);
    sel = 0;
    cyc("live");
    check("live_sel0", 64'(debug), 64'h11111111);

    // hold
    mode = 2'b01; sel = 1; set_ch(1, 32'h12); ch_valid = 4'b0010;
    cyc("hold");
    ch_valid = 4'b0000; set_ch(1, 32'h34);
    cyc("hold");
    cyc("hold");
    check("hold_keep", 64'(debug), 64'h12);

    // triggered capture
    mode = 2'b10; sel = 0; trig_mask = 32'hFFFFFFFF; trig_value = 32'd5; arm = 1;
    cyc("arm");
    arm = 0; ch_valid = 4'b0001;
    for (int i = 1; i <= 12; i++) begin
      set_ch(0, 32'(i));
      cyc("trig");
      check("trig_flag", 64'(triggered), 64'(i >= 5));
      check("trig_done", 64'(capture_done), 64'(i >= 9));
    end
    ch_valid = 4'b0000;
    cyc("trig");
    check("cap_debug", 64'(debug), 64'd5);
    check("cap_hist", 64'(hist_count), 64'd8);

    // playback with level-held step
    mode = 2'b11;
    cyc("pb");
    check("pb_start", 64'(debug), 64'd5);
    for (int k = 0; k < 8; k++) begin
      step = 1;
      cyc("pb");
      cyc("pb");
      check("pb_step", 64'(debug), 64'(pb_exp[k]));
      step = 0;
      cyc("pb");
      check("pb_level", 64'(debug), 64'(pb_exp[k]));
    end

    // arm collides with a matching sample
    mode = 2'b10; sel = 0; trig_value = 32'd7; set_ch(0, 32'd7); ch_valid = 4'b0001; arm = 1;
    cyc("coll");
    arm = 0; ch_valid = 4'b0000;
    cyc("coll");
    check("coll_trig", 64'(triggered), 64'd0);
    check("coll_hist", 64'(hist_count), 64'd0);
    ch_valid = 4'b0001;
    cyc("coll");
    check("coll_next", 64'(triggered), 64'd1);

    // reset during POST
    set_ch(0, 32'd8);
    cyc("post");
    resetp = 1;
    cyc("rst");
    check("rst_debug", 64'(debug), 64'd0);
    check("rst_trig", 64'(triggered), 64'd0);
    check("rst_done", 64'(capture_done), 64'd0);
    check("rst_hist", 64'(hist_count), 64'd0);
    resetp = 0; set_ch(0, 32'd7);
    for (int i = 0; i < 3; i++) cyc("idle");
    check("idle_hist", 64'(hist_count), 64'd0);

    // zero mask triggers on first valid sample
    trig_mask = '0; trig_value = 32'd123; set_ch(0, 32'd999); arm = 1;
    cyc("mask0");
    arm = 0; set_ch(0, 32'd42);
    cyc("mask0");
    check("mask0_trig", 64'(triggered), 64'd1);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      resetp = ($urandom_range(0, 149) == 0);
      arm    = !resetp && (c == 0 || $urandom_range(0, 29) == 0);
      if (arm) begin
        case ($urandom_range(0, 3))
          0: trig_mask = 32'hF;
          1: trig_mask = 32'h3;
          2: trig_mask = 32'h0;
          default: trig_mask = 32'h8;
        endcase
        trig_value = $urandom_range(0, 15);
      end
      sel      = 2'($urandom_range(0, 3));
      mode     = 2'($urandom_range(0, 3));
      ch_valid = 4'($urandom_range(0, 15));
      for (int n = 0; n < 4; n++) set_ch(n, $urandom_range(0, 15));
      if (!m_done)                        step = 0;
      else if ($urandom_range(0, 1) == 1) step = ~step;
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
